// File: rtl/crc_sig_pkg.sv
// Shared definitions for the CRC/signature checker: FSM state encoding and
// the default 64-bit feedback taps and seed.
package crc_sig_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEED  = 3'd1,
        ST_WARM  = 3'd2,
        ST_RUN   = 3'd3,
        ST_CHECK = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [63:0] CRC_TAPS = 64'h8000_0000_0000_0005;
    localparam logic [63:0] CRC_SEED = 64'h5aef0c8d_d70a4497;

endpackage

// File: rtl/misr_reg.sv
// Shift register with XOR feedback. With data tied to 0 it is a plain LFSR;
// with live data it compacts that data into a multiple-input signature.
module misr_reg
    import crc_sig_pkg::*;
#(
    parameter int               WIDTH = 64,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(CRC_TAPS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] q
);

    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] x);
        return {x[WIDTH-2:0], ^(x & TAPS)};
    endfunction

    // Load wins over stepping so a fresh run always starts from load_val.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (en) begin
            q <= data ^ step(q);
        end
    end

endmodule

// File: rtl/crc_sig_checker.sv
// Self-test sequencer: drives LFSR stimulus, compacts the DUT response into a
// signature, and compares both against golden values at the last run cycle.
module crc_sig_checker
    import crc_sig_pkg::*;
#(
    parameter int               WIDTH     = 64,
    parameter logic [WIDTH-1:0] TAPS      = WIDTH'(CRC_TAPS),
    parameter logic [WIDTH-1:0] SEED      = WIDTH'(CRC_SEED),
    parameter int               WARM_CYC  = 10,
    parameter int               TOTAL_CYC = 100,
    localparam int              CW        = $clog2(TOTAL_CYC + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] result,
    input  logic             result_valid,
    input  logic [WIDTH-1:0] exp_crc,
    input  logic [WIDTH-1:0] exp_sig,
    output logic [WIDTH-1:0] stim,
    output logic             stim_valid,
    output logic [CW-1:0]    cyc,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail
);

    if (WIDTH < 2 || WARM_CYC < 1 || TOTAL_CYC < WARM_CYC + 2 || TAPS[WIDTH-1] != 1'b1) begin : g_param_check
        $error("crc_sig_checker: illegal parameter combination");
    end

    state_t           state;
    logic [WIDTH-1:0] sig;
    logic             seed_load;
    logic             lfsr_en;
    logic             sig_en;
    logic             verdict;

    assign busy       = (state == ST_SEED) || (state == ST_WARM) ||
                        (state == ST_RUN)  || (state == ST_CHECK);
    assign stim_valid = (state == ST_WARM) || (state == ST_RUN);

    // An abort must not disturb the registers on the way out of a run.
    assign seed_load = (state == ST_SEED) && !abort;
    assign lfsr_en   = stim_valid && !abort;
    assign sig_en    = (state == ST_RUN) && result_valid && !abort;
    assign verdict   = (stim == exp_crc) && (sig == exp_sig);

    misr_reg #(.WIDTH(WIDTH), .TAPS(TAPS)) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .load     (seed_load),
        .load_val (SEED),
        .en       (lfsr_en),
        .data     ('0),
        .q        (stim)
    );

    misr_reg #(.WIDTH(WIDTH), .TAPS(TAPS)) u_sig (
        .clk      (clk),
        .reset    (reset),
        .load     (seed_load),
        .load_val ('0),
        .en       (sig_en),
        .data     (result),
        .q        (sig)
    );

    // Sequencer: cyc counts run cycles, abort overrides everything including the verdict.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cyc   <= '0;
            done  <= 1'b0;
            pass  <= 1'b0;
            fail  <= 1'b0;
        end else if (busy && abort) begin
            state <= ST_IDLE;
            done  <= 1'b0;
            pass  <= 1'b0;
            fail  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state <= ST_SEED;
                        cyc   <= '0;
                        done  <= 1'b0;
                        pass  <= 1'b0;
                        fail  <= 1'b0;
                    end
                end
                ST_SEED: begin
                    cyc   <= cyc + CW'(1);
                    state <= (WARM_CYC > 1) ? ST_WARM : ST_RUN;
                end
                ST_WARM: begin
                    cyc <= cyc + CW'(1);
                    if (cyc == CW'(WARM_CYC - 1)) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    cyc <= cyc + CW'(1);
                    if (cyc == CW'(TOTAL_CYC - 2)) begin
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    cyc   <= cyc + CW'(1);
                    pass  <= verdict;
                    fail  <= !verdict;
                    done  <= 1'b1;
                    state <= ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc_sig_checker.sv
// Bench for crc_sig_checker: default 64-bit instance checked against golden
// constants and a stimulus scoreboard, plus an 8-bit instance for LFSR period.
module tb_crc_sig_checker;

    localparam logic [63:0] TAPS64   = 64'h8000_0000_0000_0005;
    localparam logic [63:0] SEED64   = 64'h5aef0c8d_d70a4497;
    localparam logic [63:0] GOLD_CRC = 64'hc77bb9b3784ea091;
    localparam logic [63:0] GOLD_SIG = 64'h4afe43fb79d7b71e;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [63:0] result;
    logic        result_valid;
    logic [63:0] exp_crc = '0;
    logic [63:0] exp_sig = '0;
    logic [63:0] stim;
    logic        stim_valid;
    logic [6:0]  cyc;
    logic        busy, done, pass, fail;

    logic        start8 = 1'b0;
    logic [7:0]  exp_crc8 = '0;
    logic [7:0]  stim8;
    logic        stim_valid8;
    logic [8:0]  cyc8;
    logic        busy8, done8, pass8, fail8;

    bit          use_reg = 1'b0;
    bit          gap_mode = 1'b0;
    logic [63:0] stim_q = '0;
    logic [63:0] sb[$];
    int          checks = 0;
    int          passed = 0;

    always #5 clk = ~clk;

    // Response source: the low half of the previous cycle's stimulus.
    always @(posedge clk) stim_q <= stim;
    assign result       = use_reg ? {32'h0, stim_q[31:0]} : 64'h0;
    assign result_valid = !(gap_mode && cyc >= 7'd20 && cyc <= 7'd29);

    crc_sig_checker dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .result(result), .result_valid(result_valid),
        .exp_crc(exp_crc), .exp_sig(exp_sig),
        .stim(stim), .stim_valid(stim_valid), .cyc(cyc),
        .busy(busy), .done(done), .pass(pass), .fail(fail)
    );

    crc_sig_checker #(
        .WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .WARM_CYC(1), .TOTAL_CYC(257)
    ) dut8 (
        .clk(clk), .reset(reset), .start(start8), .abort(1'b0),
        .result(8'h00), .result_valid(1'b0),
        .exp_crc(exp_crc8), .exp_sig(8'h00),
        .stim(stim8), .stim_valid(stim_valid8), .cyc(cyc8),
        .busy(busy8), .done(done8), .pass(pass8), .fail(fail8)
    );

    function automatic logic [63:0] step64(input logic [63:0] x);
        return {x[62:0], ^(x & TAPS64)};
    endfunction

    task automatic test_reset;
        @(negedge clk);
        checks++; if (stim !== 64'h0) $display("[TB] FAIL reset_stim got %h want 0", stim); else passed++;
        checks++; if (cyc !== 7'd0) $display("[TB] FAIL reset_cyc got %0d want 0", cyc); else passed++;
        checks++; if ({stim_valid, busy, done, pass, fail} !== 5'b0)
            $display("[TB] FAIL reset_flags got %b want 00000", {stim_valid, busy, done, pass, fail}); else passed++;
        checks++; if ({stim8, busy8, done8} !== 10'h0)
            $display("[TB] FAIL reset_dut8 got %h want 0", {stim8, busy8, done8}); else passed++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Full default run; the stimulus sequence is predicted into the scoreboard at start.
    task automatic run_default(input string name, input logic [63:0] ecrc,
                               input logic [63:0] esig, input bit exp_pass);
        logic [63:0] s;
        logic [63:0] want;
        exp_crc = ecrc;
        exp_sig = esig;
        s = SEED64;
        for (int k = 1; k <= 99; k++) begin
            sb.push_back(s);
            s = step64(s);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (cyc !== 7'd0 || busy !== 1'b1 || stim_valid !== 1'b0)
            $display("[TB] FAIL %s_seed got cyc=%0d busy=%b sv=%b want 0/1/0", name, cyc, busy, stim_valid); else passed++;
        for (int k = 1; k <= 99; k++) begin
            @(negedge clk);
            want = sb.pop_front();
            checks++; if (stim !== want)
                $display("[TB] FAIL %s_stim cyc %0d got %h want %h", name, k, stim, want); else passed++;
            checks++; if (cyc !== 7'(k) || stim_valid !== (k <= 98) || busy !== 1'b1)
                $display("[TB] FAIL %s_cycle %0d got cyc=%0d sv=%b busy=%b", name, k, cyc, stim_valid, busy); else passed++;
        end
        checks++; if (stim !== GOLD_CRC)
            $display("[TB] FAIL %s_final_crc got %h want %h", name, stim, GOLD_CRC); else passed++;
        @(negedge clk);
        checks++; if (cyc !== 7'd100 || done !== 1'b1 || busy !== 1'b0)
            $display("[TB] FAIL %s_done got cyc=%0d done=%b busy=%b want 100/1/0", name, cyc, done, busy); else passed++;
        checks++; if (pass !== exp_pass || fail !== !exp_pass)
            $display("[TB] FAIL %s_verdict got pass=%b fail=%b want pass=%b", name, pass, fail, exp_pass); else passed++;
        repeat (2) @(negedge clk);
        checks++; if (done !== 1'b1 || pass !== exp_pass)
            $display("[TB] FAIL %s_hold got done=%b pass=%b", name, done, pass); else passed++;
    endtask

    task automatic test_golden;
        use_reg = 1'b0;
        gap_mode = 1'b0;
        run_default("golden", GOLD_CRC, 64'h0, 1'b1);
    endtask

    task automatic test_misr;
        use_reg = 1'b1;
        gap_mode = 1'b0;
        run_default("misr_pass", GOLD_CRC, GOLD_SIG, 1'b1);
        run_default("misr_flip", GOLD_CRC, GOLD_SIG ^ 64'h1, 1'b0);
        gap_mode = 1'b1;
        run_default("misr_gap", GOLD_CRC, GOLD_SIG, 1'b0);
        gap_mode = 1'b0;
        use_reg = 1'b0;
    endtask

    task automatic test_abort;
        exp_crc = GOLD_CRC;
        exp_sig = 64'h0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (cyc !== 7'd31 || busy !== 1'b1)
            $display("[TB] FAIL start_ignored got cyc=%0d busy=%b want 31/1", cyc, busy); else passed++;
        repeat (19) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++; if ({busy, stim_valid, done, pass, fail} !== 5'b0)
            $display("[TB] FAIL abort_run got %b want 00000", {busy, stim_valid, done, pass, fail}); else passed++;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (99) @(negedge clk);
        checks++; if (cyc !== 7'd99 || busy !== 1'b1 || stim_valid !== 1'b0)
            $display("[TB] FAIL check_cycle got cyc=%0d busy=%b sv=%b", cyc, busy, stim_valid); else passed++;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++; if ({busy, done, pass, fail} !== 4'b0)
            $display("[TB] FAIL abort_check got %b want 0000", {busy, done, pass, fail}); else passed++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_midrun;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        checks++; if (cyc !== 7'd40 || stim === 64'h0)
            $display("[TB] FAIL pre_reset got cyc=%0d stim=%h", cyc, stim); else passed++;
        #2 reset = 1'b1;
        #1;
        checks++; if (stim !== 64'h0 || cyc !== 7'd0)
            $display("[TB] FAIL async_reset got stim=%h cyc=%0d want 0/0", stim, cyc); else passed++;
        checks++; if ({stim_valid, busy, done, pass, fail} !== 5'b0)
            $display("[TB] FAIL async_flags got %b want 00000", {stim_valid, busy, done, pass, fail}); else passed++;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0)
            $display("[TB] FAIL post_reset_idle got busy=%b want 0", busy); else passed++;
        run_default("after_reset", GOLD_CRC, 64'h0, 1'b1);
    endtask

    task automatic test_lfsr8;
        bit seen[256];
        int distinct = 0;
        int zeros = 0;
        exp_crc8 = 8'h01;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        for (int k = 1; k <= 255; k++) begin
            @(negedge clk);
            if (stim8 == 8'h00) zeros++;
            else if (!seen[stim8]) begin
                seen[stim8] = 1'b1;
                distinct++;
            end
        end
        checks++; if (distinct != 255 || zeros != 0)
            $display("[TB] FAIL lfsr8_period got distinct=%0d zeros=%0d want 255/0", distinct, zeros); else passed++;
        @(negedge clk);
        checks++; if (stim8 !== 8'h01 || cyc8 !== 9'd256 || stim_valid8 !== 1'b0)
            $display("[TB] FAIL lfsr8_check got stim=%h cyc=%0d sv=%b want 01/256/0", stim8, cyc8, stim_valid8); else passed++;
        @(negedge clk);
        checks++; if (done8 !== 1'b1 || pass8 !== 1'b1 || fail8 !== 1'b0 || cyc8 !== 9'd257)
            $display("[TB] FAIL lfsr8_done got done=%b pass=%b fail=%b cyc=%0d", done8, pass8, fail8, cyc8); else passed++;
    endtask

    initial begin
        test_reset();
        test_golden();
        test_misr();
        test_abort();
        test_reset_midrun();
        test_lfsr8();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/crc_sig_checker.md
CRC_SIG_CHECKER -- requirements
Module: crc_sig_checker

Interface
REQ-001 Parameter WIDTH, default 64, sets the LFSR, stimulus, result and signature width in bits.
REQ-002 Parameter TAPS, default 64'h8000_0000_0000_0005, is the feedback tap mask (bit i set means state bit i feeds the XOR).
REQ-003 Parameter SEED, default 64'h5aef0c8d_d70a4497, is the LFSR load value.
REQ-004 Parameter WARM_CYC, default 10, is the run-cycle index at which signature accumulation begins.
REQ-005 Parameter TOTAL_CYC, default 100, is the run length in cycles; the check occurs at run cycle TOTAL_CYC-1.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 start  input  1  one-cycle pulse that begins a run.
REQ-009 abort  input  1  terminates a run immediately, with no verdict.
REQ-010 result  input  WIDTH  DUT response to be compacted.
REQ-011 result_valid  input  1  qualifies result for compaction.
REQ-012 exp_crc, exp_sig  input  WIDTH each  golden values compared at the check cycle.
REQ-013 stim  output  WIDTH  current LFSR state, driven to the DUT.
REQ-014 stim_valid  output  1  high in WARM and RUN states.
REQ-015 cyc  output  $clog2(TOTAL_CYC+1)  current run-cycle index.
REQ-016 busy, done, pass, fail  output  1 each  status flags.

Function
REQ-017 The FSM SHALL have states IDLE, SEED, WARM, RUN, CHECK and DONE.
REQ-018 The LFSR step SHALL be next = {x[WIDTH-2:0], ^(x & TAPS)}; the MISR step SHALL be next = data ^ step(x).
REQ-019 IDLE or DONE with start=1 SHALL go to SEED, setting cyc to 0 and clearing pass and fail; start SHALL be ignored in every other state.
REQ-020 SEED, run cycle 0, lasts one cycle: the LFSR loads SEED, the signature loads 0, and cyc increments.
REQ-021 WARM, run cycles 1..WARM_CYC-1: the LFSR steps, the signature is held at 0, and cyc increments.
REQ-022 RUN, run cycles WARM_CYC..TOTAL_CYC-2: the LFSR steps every cycle; the signature SHALL take MISR(result) when result_valid=1 and SHALL hold otherwise.
REQ-023 CHECK, run cycle TOTAL_CYC-1, lasts one cycle: the LFSR and signature freeze; pass is set when stim==exp_crc and sig==exp_sig, and fail is set otherwise.
REQ-024 The FSM SHALL enter DONE after CHECK; done, pass and fail then hold until the next start or reset.
REQ-025 abort=1 in SEED, WARM, RUN or CHECK SHALL return the FSM to IDLE next cycle with done, pass and fail at 0; abort has priority over the CHECK verdict.
REQ-026 busy SHALL be 1 exactly in SEED, WARM, RUN and CHECK; pass and fail SHALL never both be 1.
REQ-027 Elaboration SHALL fail unless WIDTH>=2, WARM_CYC>=1, TOTAL_CYC>=WARM_CYC+2 and TAPS[WIDTH-1]=1.

Reset
REQ-028 reset=1 SHALL force IDLE, stim=0, signature=0, cyc=0, and stim_valid, busy, done, pass and fail all to 0, regardless of clk.
REQ-029 Asserting reset mid-run SHALL discard the run; the first start after release SHALL begin a fresh SEED.

Structure
REQ-030 Package crc_sig_pkg SHALL hold the state enum and the default TAPS and SEED constants.
REQ-031 One sub-module, misr_reg (parameters WIDTH and TAPS; inputs load, load_val, en, data), SHALL be instantiated twice: once as the stimulus LFSR with data=0, and once as the signature register.

Verification
REQ-032 Defaults, start pulse, result=0 throughout -> at cyc 99 stim=64'hc77bb9b3784ea091; with exp_crc equal to that value and exp_sig=0, pass=1 and done=1 at cyc 100.
REQ-033 Defaults, result={32'h0, stim[31:0] registered one cycle}, result_valid=1 -> signature at CHECK = 64'h4afe43fb79d7b71e; matching exp_* gives pass=1, and flipping exp_sig bit 0 gives fail=1.
REQ-034 As REQ-033, but result_valid=0 on run cycles 20..29 -> signature differs from 64'h4afe43fb79d7b71e, stim is still 64'hc77bb9b3784ea091, and fail=1.
REQ-035 abort at cyc 50 -> IDLE next cycle with done=0; a start during RUN is ignored, and cyc continues without reload.
REQ-036 reset asserted at cyc 40 between clock edges -> outputs 0 immediately; after release and start, the REQ-032 result is reproduced.
REQ-037 WIDTH=8, TAPS=8'hB8, SEED=8'h01, WARM_CYC=1, TOTAL_CYC=257 -> stim visits 255 distinct nonzero values, and stim==8'h01 at the check cycle.
